// File: rtl/ram_arbiter_if.sv
// Avalon-MM style master port bundle used on each arbiter input.
// The master drives the request; the slave drives stall and read return.
interface ram_arbiter_if #(
    parameter int AW = 11,
    parameter int DW = 32
);
    logic [AW-1:0]   address;
    logic [DW/8-1:0] byteenable;
    logic            read;
    logic            write;
    logic [DW-1:0]   writedata;
    logic            waitrequest;
    logic [DW-1:0]   readdata;
    logic            readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port 1-cycle-latency RAM.
// Optional RAM_ARBITER_CLEAR_ON_RESET_EN: zero the whole RAM after reset before serving masters.
module ram_arbiter #(
    parameter int DEPTH = 1536,
    parameter int AW    = 11,
    parameter int DW    = 32
) (
    input  logic            clk,
    input  logic            reset,
    ram_arbiter_if.slave    m0,
    ram_arbiter_if.slave    m1,
    output logic [AW-1:0]   ram_address,
    output logic [DW/8-1:0] ram_byteenable,
    output logic            ram_chipselect,
    output logic            ram_write,
    output logic [DW-1:0]   ram_writedata,
    output logic            ram_clken,
    input  logic [DW-1:0]   ram_readdata
);
    localparam int BW = DW / 8;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

`ifdef RAM_ARBITER_CLEAR_ON_RESET_EN
    typedef enum logic [0:0] {RUN, CLEAR} state_t;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    logic [AW-1:0] clr_cnt_reg;
`else
    typedef enum logic [0:0] {RUN} state_t;
`endif

    state_t          state_reg;
    logic            last_grant_reg;
    logic            rd_pend_reg;
    logic            rd_owner_reg;
    logic            rd_oor_reg;
    logic [AW-1:0]   addr_hold_reg;
    logic [BW-1:0]   be_hold_reg;
    logic [DW-1:0]   wd_hold_reg;

    logic            req0, req1, run;
    logic            grant0, grant1, g_any, g_sel;
    logic [AW-1:0]   g_addr;
    logic [BW-1:0]   g_be;
    logic [DW-1:0]   g_wd;
    logic            g_write, g_read, in_range, clearing;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;
    assign run  = (state_reg == RUN) && !reset;

    // On contention the master that did not win last time is served.
    assign grant0 = run & req0 & (~req1 | last_grant_reg);
    assign grant1 = run & req1 & (~req0 | ~last_grant_reg);
    assign g_any  = grant0 | grant1;
    assign g_sel  = grant1;

    assign g_addr   = g_sel ? m1.address    : m0.address;
    assign g_be     = g_sel ? m1.byteenable : m0.byteenable;
    assign g_wd     = g_sel ? m1.writedata  : m0.writedata;
    assign g_write  = g_sel ? m1.write      : m0.write;
    assign g_read   = g_sel ? (m1.read & ~m1.write) : (m0.read & ~m0.write);
    assign in_range = {1'b0, g_addr} < DEPTH_W;

`ifdef RAM_ARBITER_CLEAR_ON_RESET_EN
    assign clearing = (state_reg == CLEAR) && !reset;
`else
    assign clearing = 1'b0;
`endif

    assign ram_clken = 1'b1;

    always_comb begin
        ram_address    = addr_hold_reg;
        ram_byteenable = be_hold_reg;
        ram_writedata  = wd_hold_reg;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        if (clearing) begin
`ifdef RAM_ARBITER_CLEAR_ON_RESET_EN
            ram_address    = clr_cnt_reg;
`endif
            ram_byteenable = '1;
            ram_writedata  = '0;
            ram_chipselect = 1'b1;
            ram_write      = 1'b1;
        end else if (g_any) begin
            ram_address    = g_addr;
            ram_byteenable = g_be;
            ram_writedata  = g_wd;
            ram_chipselect = 1'b1;
            ram_write      = g_write & in_range;
        end
    end

    assign m0.waitrequest = ~grant0;
    assign m1.waitrequest = ~grant1;

    // Read return is gated by reset so a read in flight when reset rises is dropped.
    assign m0.readdatavalid = rd_pend_reg & ~rd_owner_reg & ~reset;
    assign m1.readdatavalid = rd_pend_reg &  rd_owner_reg & ~reset;
    assign m0.readdata = (m0.readdatavalid & ~rd_oor_reg) ? ram_readdata : '0;
    assign m1.readdata = (m1.readdatavalid & ~rd_oor_reg) ? ram_readdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef RAM_ARBITER_CLEAR_ON_RESET_EN
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
`else
            state_reg   <= RUN;
`endif
            last_grant_reg <= 1'b1;
            rd_pend_reg    <= 1'b0;
            rd_owner_reg   <= 1'b0;
            rd_oor_reg     <= 1'b0;
            addr_hold_reg  <= '0;
            be_hold_reg    <= '0;
            wd_hold_reg    <= '0;
        end else begin
            rd_pend_reg <= g_any & g_read;
            if (g_any & g_read) begin
                rd_owner_reg <= g_sel;
                rd_oor_reg   <= ~in_range;
            end
            if (g_any) begin
                last_grant_reg <= g_sel;
                addr_hold_reg  <= g_addr;
                be_hold_reg    <= g_be;
                wd_hold_reg    <= g_wd;
            end
`ifdef RAM_ARBITER_CLEAR_ON_RESET_EN
            if (state_reg == CLEAR) begin
                clr_cnt_reg <= clr_cnt_reg + 1'b1;
                if (clr_cnt_reg == LAST_ADDR) begin
                    state_reg <= RUN;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized traffic checked
// against a word-level memory model and a round-robin grant predictor.
module tb_ram_arbiter;
    localparam int DEPTH = 1536;
    localparam int AW    = 11;
    localparam int DW    = 32;
`ifdef RAM_ARBITER_CLEAR_ON_RESET_EN
    localparam int READY_LAT = DEPTH;
`else
    localparam int READY_LAT = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ram_arbiter_if #(.AW(AW), .DW(DW)) m0if ();
    ram_arbiter_if #(.AW(AW), .DW(DW)) m1if ();

    logic [AW-1:0] ram_address;
    logic [3:0]    ram_byteenable;
    logic          ram_chipselect, ram_write, ram_clken;
    logic [31:0]   ram_writedata, ram_readdata;

    ram_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .m0(m0if), .m1(m1if),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_clken(ram_clken),
        .ram_readdata(ram_readdata)
    );

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    // Physical RAM behind the arbiter: 2048 words so out-of-range reads return junk.
    logic [31:0] ram_mem [0:2047];
    bit ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 2048; i++) ram_mem[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else if (ram_clken && ram_chipselect) begin
            if (ram_write)
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            ram_readdata <= ram_mem[ram_address];
        end
    end

    typedef struct {
        bit          rd;
        bit          wr;
        logic [10:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } req_t;

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_mem [0:DEPTH-1];
    int          last_winner;
    logic [10:0] last_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic req_t mk(bit rd, bit wr, logic [10:0] addr, logic [3:0] be, logic [31:0] data);
        req_t q;
        q.rd = rd; q.wr = wr; q.addr = addr; q.be = be; q.data = data;
        return q;
    endfunction

    function automatic req_t rand_req();
        req_t q;
        int k = int'($urandom_range(0, 3));
        q.rd   = (k == 1) || (k == 3);
        q.wr   = (k >= 2);
        q.addr = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(0, 31))
                                              : 11'($urandom_range(32'h5F0, 32'h60F));
        q.be   = 4'($urandom);
        q.data = $urandom;
        return q;
    endfunction

    task automatic drive(input req_t q0, input req_t q1);
        m0if.read = q0.rd; m0if.write = q0.wr; m0if.address = q0.addr;
        m0if.byteenable = q0.be; m0if.writedata = q0.data;
        m1if.read = q1.rd; m1if.write = q1.wr; m1if.address = q1.addr;
        m1if.byteenable = q1.be; m1if.writedata = q1.data;
    endtask

    task automatic model_reset();
        last_winner = 1;
        last_addr   = '0;
`ifdef RAM_ARBITER_CLEAR_ON_RESET_EN
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
    endtask

    // One bus cycle: called at posedge+1, returns at the next posedge+1 after
    // checking the grant and the read return it caused.
    task automatic step(input req_t q0, input req_t q1, output int g);
        bit r0, r1, ev0, ev1;
        logic [31:0] ed;
        req_t qg;
        drive(q0, q1);
        #2;
        r0 = q0.rd | q0.wr;
        r1 = q1.rd | q1.wr;
        if (r0 && r1)  g = (last_winner == 0) ? 1 : 0;
        else if (r0)   g = 0;
        else if (r1)   g = 1;
        else           g = -1;
        chkb("m0_waitrequest", m0if.waitrequest, g != 0);
        chkb("m1_waitrequest", m1if.waitrequest, g != 1);
        chkb("ram_chipselect", ram_chipselect, g >= 0);
        ev0 = 1'b0; ev1 = 1'b0; ed = '0;
        if (g >= 0) begin
            qg = (g == 1) ? q1 : q0;
            chk("ram_address", 32'(ram_address), 32'(qg.addr));
            chkb("ram_write", ram_write, qg.wr && (int'(qg.addr) < DEPTH));
            last_winner = g;
            last_addr   = qg.addr;
            if (qg.wr) begin
                if (int'(qg.addr) < DEPTH)
                    for (int b = 0; b < 4; b++)
                        if (qg.be[b]) ref_mem[qg.addr][8*b +: 8] = qg.data[8*b +: 8];
            end else begin
                ed = (int'(qg.addr) < DEPTH) ? ref_mem[qg.addr] : 32'h0;
                if (g == 0) ev0 = 1'b1; else ev1 = 1'b1;
            end
        end else begin
            chkb("ram_write_idle", ram_write, 1'b0);
            chk("ram_address_hold", 32'(ram_address), 32'(last_addr));
        end
        @(posedge clk); #1;
        chkb("m0_readdatavalid", m0if.readdatavalid, ev0);
        chk("m0_readdata", m0if.readdata, ev0 ? ed : 32'h0);
        chkb("m1_readdatavalid", m1if.readdatavalid, ev1);
        chk("m1_readdata", m1if.readdata, ev1 ? ed : 32'h0);
    endtask

    task automatic wait_ready(input int exp_n);
        int n = 0;
        #1;
        while (m0if.waitrequest === 1'b1 && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_latency", 32'(n), 32'(exp_n));
    endtask

    initial begin
        req_t idle, q0, q1;
        int g, cnt0, cnt1;
        idle = mk(0, 0, 11'h0, 4'h0, 32'h0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

        // Reset with both masters requesting
        reset = 1'b1;
        drive(mk(1, 0, 11'h5FF, 4'hF, 0), mk(1, 0, 11'h005, 4'hF, 0));
        repeat (3) @(posedge clk);
        #1;
        chkb("rst_m0_waitrequest", m0if.waitrequest, 1'b1);
        chkb("rst_m1_waitrequest", m1if.waitrequest, 1'b1);
        chkb("rst_m0_readdatavalid", m0if.readdatavalid, 1'b0);
        chkb("rst_m1_readdatavalid", m1if.readdatavalid, 1'b0);
        chk("rst_m0_readdata", m0if.readdata, 32'h0);
        chk("rst_m1_readdata", m1if.readdata, 32'h0);
        chkb("rst_ram_chipselect", ram_chipselect, 1'b0);
        chkb("rst_ram_write", ram_write, 1'b0);
        chkb("rst_ram_clken", ram_clken, 1'b1);

        // Release with m0 read pending on the top word
        reset = 1'b0;
        drive(mk(1, 0, 11'h5FF, 4'hF, 0), idle);
        model_reset();
        wait_ready(READY_LAT);
        step(mk(1, 0, 11'h5FF, 4'hF, 0), idle, g);
`ifdef RAM_ARBITER_CLEAR_ON_RESET_EN
        chk("t6_cleared_5ff", m0if.readdata, 32'h0);
`endif
        step(idle, idle, g);

        // m0 write then read back
        step(mk(0, 1, 11'h010, 4'hF, 32'hDEADBEEF), idle, g);
        step(mk(1, 0, 11'h010, 4'hF, 0), idle, g);
        chk("t1_readback", m0if.readdata, 32'hDEADBEEF);

        // m1 partial-byte write over a known word
        step(idle, mk(0, 1, 11'h005, 4'hF, 32'hAAAAAAAA), g);
        step(idle, mk(0, 1, 11'h005, 4'b0011, 32'h11223344), g);
        step(idle, mk(1, 0, 11'h005, 4'hF, 0), g);
        chk("t3_merge", m1if.readdata, 32'hAAAA3344);

        // Continuous contention: alternating grants starting with m0
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 6; i++) begin
            step(mk(1, 0, 11'h010, 4'hF, 0), mk(1, 0, 11'h005, 4'hF, 0), g);
            chk("t2_grant", 32'(g), 32'(i % 2));
            cnt0 += int'(m0if.readdatavalid);
            cnt1 += int'(m1if.readdatavalid);
        end
        chk("t2_m0_pulses", 32'(cnt0), 32'd3);
        chk("t2_m1_pulses", 32'(cnt1), 32'd3);

        // Out-of-range write and read
        step(mk(0, 1, 11'h600, 4'hF, 32'h12345678), idle, g);
        step(mk(1, 0, 11'h600, 4'hF, 0), idle, g);
        chk("t4_oor_read", m0if.readdata, 32'h0);
        chkb("t4_oor_valid", m0if.readdatavalid, 1'b1);
        step(mk(1, 0, 11'h000, 4'hF, 0), idle, g);
        step(idle, idle, g);

        // Reset the cycle after an m0 read is accepted
        drive(mk(1, 0, 11'h010, 4'hF, 0), idle);
        #2;
        chkb("t5_accept", m0if.waitrequest, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(mk(1, 0, 11'h010, 4'hF, 0), mk(1, 0, 11'h005, 4'hF, 0));
        #1;
        chkb("t5_no_valid", m0if.readdatavalid, 1'b0);
        chkb("t5_m0_wait", m0if.waitrequest, 1'b1);
        chkb("t5_m1_wait", m1if.waitrequest, 1'b1);
        @(posedge clk); #1;
        chkb("t5_no_valid_late", m0if.readdatavalid, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        wait_ready(READY_LAT);
        step(mk(1, 0, 11'h010, 4'hF, 0), mk(1, 0, 11'h005, 4'hF, 0), g);
        chk("t5_first_contention", 32'(g), 32'd0);
        step(idle, mk(1, 0, 11'h005, 4'hF, 0), g);
        step(idle, idle, g);

        // Randomized traffic; a stalled master holds its request
        q0 = rand_req();
        q1 = rand_req();
        for (int i = 0; i < 400; i++) begin
            step(q0, q1, g);
            if (g == 0 || !(q0.rd || q0.wr)) q0 = rand_req();
            if (g == 1 || !(q1.rd || q1.wr)) q1 = rand_req();
        end
        step(idle, idle, g);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-master round-robin arbiter that shares the single-port 1536x32 on-chip RAM (11-bit word address, 4-bit byte enable, 1-cycle read latency) between two Avalon-MM style masters.
- Sits between the masters (e.g. CPU data port and a DMA engine) and the RAM's single slave port.
- Generates waitrequest and readdatavalid, and routes returned read data to the master that issued the read.

Parameters:
- DEPTH, 1536, number of implemented RAM words; addresses >= DEPTH are out of range.
- AW, 11, address width in words.
- DW, 32, data width; byte enable width is DW/8.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- m0_address  in  AW  master 0 word address.
- m0_byteenable  in  4  master 0 byte lanes.
- m0_read  in  1  master 0 read request.
- m0_write  in  1  master 0 write request.
- m0_writedata  in  DW  master 0 write data.
- m0_waitrequest  out  1  master 0 stall; transfer accepted in a cycle where request=1 and waitrequest=0.
- m0_readdata  out  DW  master 0 read data, valid with m0_readdatavalid.
- m0_readdatavalid  out  1  master 0 read data strobe.
- m1_*  same set as m0_*  master 1.
- ram_address  out  AW  to RAM address.
- ram_byteenable  out  4  to RAM byteenable.
- ram_chipselect  out  1  to RAM chipselect.
- ram_write  out  1  to RAM write.
- ram_writedata  out  DW  to RAM writedata.
- ram_clken  out  1  to RAM clken.
- ram_readdata  in  DW  from RAM readdata, valid 1 cycle after a read is presented.

Behaviour:
- Reset values:
  - last_grant=1, so m0 wins the first contention.
  - rd_pend=0, rd_owner=0.
  - All readdatavalid=0, all readdata=0.
  - ram_chipselect=0, ram_write=0.
  - ram_clken=1.
  - m0_waitrequest=m1_waitrequest=1 while reset is high.
- Request: req_n = mN_read | mN_write.
  - If both read and write are high on one master, the cycle is treated as a write; no readdatavalid is generated.
- Arbitration (combinational, same cycle, state RUN):
  - Only one master requests: that master is granted.
  - Both request: grant the master != last_grant.
  - On any accepted transfer, last_grant <= granted master.
- Waitrequest: mN_waitrequest = ~(state==RUN & grant==N).
  - An idle master sees waitrequest=1 unless it would be granted.
  - Masters must hold request signals stable while stalled.
- RAM drive in the grant cycle:
  - ram_address/byteenable/writedata = granted master's signals.
  - ram_chipselect=1.
  - ram_write = granted write & in-range.
  - No grant: chipselect=0, write=0, address holds its last value.
- Read return:
  - An accepted read sets rd_pend<=1 and rd_owner<=N for the following cycle.
  - Next cycle: mN_readdatavalid=1 and mN_readdata=ram_readdata for the owner; the other master sees readdata=0 and readdatavalid=0.
  - Back-to-back reads are sustained every cycle, with one read in flight per cycle and no bubble.
- Range check:
  - Address >= DEPTH: the write is accepted (waitrequest=0) but ram_write=0.
  - Address >= DEPTH: the read is accepted and returns readdatavalid with readdata=0.
- Throughput:
  - 1 transfer per cycle.
  - Under continuous contention, grants alternate m0,m1,m0,...
- Reset mid-operation: an in-flight read is dropped; no readdatavalid is issued after reset rises.
- FSM states (without optional feature): RUN only. States with the feature are listed below.

Optional Feature:
- Macro: RAM_ARBITER_CLEAR_ON_RESET_EN.
- Defined:
  - On reset release the FSM enters CLEAR.
  - A counter sweeps addresses 0..DEPTH-1, one per cycle, with ram_chipselect=1, ram_write=1, byteenable=4'hF, writedata=0.
  - Both masters see waitrequest=1 throughout.
  - After writing DEPTH-1 the FSM moves to RUN, exactly DEPTH cycles after reset deasserts.
  - Reset during CLEAR restarts the sweep at 0.
- Undefined: the FSM resets directly into RUN and RAM contents follow the RAM's init file.

Test Plan:
1. m0 write addr 0x010 data 0xDEADBEEF be=4'hF, then read 0x010 -> m0_waitrequest=0 both cycles; m0_readdatavalid=1 one cycle after the read with 0xDEADBEEF; m1_readdatavalid stays 0.
2. m0 and m1 both read continuously for 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1 starting with m0; each master gets 3 readdatavalid pulses, each one cycle after its grant.
3. m1 write 0x005 = 0x11223344 with be=4'b0011 over an existing 0xAAAAAAAA, then read -> returns 0xAAAA3344.
4. m0 write addr 0x600 (1536) then read 0x600 -> ram_write stays 0; readdatavalid=1 with readdata=0; word 0 unchanged.
5. Assert reset the cycle after m0 read accept -> no m0_readdatavalid; waitrequest=1 during reset; m0 wins the first contention after release.
6. RAM_ARBITER_CLEAR_ON_RESET_EN defined: release reset with m0_read pending -> waitrequest=1 for 1536 cycles; then a read of 0x5FF returns 0.
